// File: rtl/adder_rr_arbiter_if.sv
// Bundle of requester, shared-adder and result signals for adder_rr_arbiter.
// slave = arbiter side, master = environment side (requesters, adder, consumer).
interface adder_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [16*NUM_REQ-1:0] req_a;
  logic [16*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_sub;
  logic [15:0]           add_a;
  logic [15:0]           add_b;
  logic                  add_cin;
  logic [15:0]           add_s;
  logic                  add_cout;
  logic                  add_cout14;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [15:0]           rsp_sum;
  logic                  rsp_carry;
  logic                  rsp_ovf;

  modport slave (
    input  req_valid, req_a, req_b, req_sub, add_s, add_cout, add_cout14, rsp_ready,
    output req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_ovf
  );

  modport master (
    output req_valid, req_a, req_b, req_sub, add_s, add_cout, add_cout14, rsp_ready,
    input  req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_ovf
  );
endinterface

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one external 16-bit adder, with a single-entry result register.
// Optional macro ADDER_ARB_SAT_EN: saturate the captured sum on signed overflow.
module adder_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  adder_rr_arbiter_if.slave   bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]     r_ptr;
  logic                 r_rsp_valid;
  logic [ID_W-1:0]      r_rsp_id;
  logic [15:0]          r_rsp_sum;
  logic                 r_rsp_carry;
  logic                 r_rsp_ovf;

  logic [2*NUM_REQ-1:0] w_rot_full;
  logic [NUM_REQ-1:0]   w_rot;
  logic                 w_found;
  logic [PTR_W-1:0]     w_off;
  logic [PTR_W:0]       w_idx_sum;
  logic [PTR_W-1:0]     w_win;
  logic [PTR_W-1:0]     w_ptr_nxt;
  logic                 w_can_accept;
  logic                 w_take;
  logic [NUM_REQ-1:0]   w_req_ready;
  logic [15:0]          w_add_a;
  logic [15:0]          w_add_b;
  logic                 w_add_cin;
  logic                 w_ovf;
  logic [15:0]          w_sum_cap;

  // Rotating the doubled valid vector by ptr puts the search start at bit 0.
  assign w_rot_full = {bus.req_valid, bus.req_valid} >> r_ptr;
  assign w_rot      = w_rot_full[NUM_REQ-1:0];

  // Distance from ptr to the first valid requester (lowest set bit of the rotated view).
  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_off   = PTR_W'(k);
      end else begin
        w_found = w_found;
        w_off   = w_off;
      end
    end
  end

  // Absolute winner index modulo NUM_REQ and the pointer value that follows it.
  always_comb begin
    w_idx_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_idx_sum >= (PTR_W+1)'(NUM_REQ)) begin
      w_win = w_idx_sum[PTR_W-1:0] - PTR_W'(NUM_REQ);
    end else begin
      w_win = w_idx_sum[PTR_W-1:0];
    end
    if (w_win == PTR_W'(NUM_REQ - 1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = w_win + PTR_W'(1);
    end
  end

  assign w_can_accept = !r_rsp_valid || bus.rsp_ready;
  assign w_take       = rst_n && w_found && w_can_accept;

  // Operand steering to the shared adder; subtraction is A + ~B + 1.
  always_comb begin
    w_add_a     = 16'h0000;
    w_add_b     = 16'h0000;
    w_add_cin   = 1'b0;
    w_req_ready = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_found && (w_win == PTR_W'(j))) begin
        w_add_a        = bus.req_a[16*j +: 16];
        w_add_b        = bus.req_sub[j] ? ~bus.req_b[16*j +: 16] : bus.req_b[16*j +: 16];
        w_add_cin      = bus.req_sub[j];
        w_req_ready[j] = w_take;
      end else begin
        w_req_ready[j] = 1'b0;
      end
    end
  end

  assign w_ovf = bus.add_cout ^ bus.add_cout14;

  // Value captured into rsp_sum: raw sum, or clamped on overflow when saturation is built in.
  always_comb begin
`ifdef ADDER_ARB_SAT_EN
    if (w_ovf) begin
      w_sum_cap = bus.add_s[15] ? 16'h7FFF : 16'h8000;
    end else begin
      w_sum_cap = bus.add_s;
    end
`else
    w_sum_cap = bus.add_s;
`endif
  end

  // Result register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= 16'h0000;
      r_rsp_carry <= 1'b0;
      r_rsp_ovf   <= 1'b0;
    end else if (w_take) begin
      r_ptr       <= w_ptr_nxt;
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= ID_W'(w_win);
      r_rsp_sum   <= w_sum_cap;
      r_rsp_carry <= bus.add_cout;
      r_rsp_ovf   <= w_ovf;
    end else if (r_rsp_valid && bus.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end else begin
      r_rsp_valid <= r_rsp_valid;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.add_a     = w_add_a;
  assign bus.add_b     = w_add_b;
  assign bus.add_cin   = w_add_cin;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_sum   = r_rsp_sum;
  assign bus.rsp_carry = r_rsp_carry;
  assign bus.rsp_ovf   = r_rsp_ovf;
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Self-checking bench for adder_rr_arbiter: directed scenarios plus random traffic
// compared against an arithmetic reference model of arbitration and results.
module tb_adder_rr_arbiter;
  localparam int N = 4;

  logic clk;
  logic rst_n;
  adder_rr_arbiter_if #(.NUM_REQ(N), .ID_W(2)) bus ();
  adder_rr_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [N-1:0] tb_valid = '0;
  logic [N-1:0] tb_sub   = '0;
  logic [15:0]  tb_a [N];
  logic [15:0]  tb_b [N];
  logic [16:0]  add_full;
  logic [15:0]  add_low;

  int total = 0;
  int bad   = 0;

  // reference model state
  int          m_ptr   = 0;
  bit          m_valid = 1'b0;
  logic [1:0]  m_id    = 2'd0;
  logic [15:0] m_sum   = 16'h0000;
  bit          m_carry = 1'b0;
  bit          m_ovf   = 1'b0;
  int          m_xfer  = -1;
  int          e_win;
  bit          e_take;
  logic [N-1:0] e_ready;
  logic [15:0] e_add_a, e_add_b;
  logic        e_cin;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    bus.req_valid = tb_valid;
    bus.req_sub   = tb_sub;
    for (int i = 0; i < N; i++) begin
      bus.req_a[16*i +: 16] = tb_a[i];
      bus.req_b[16*i +: 16] = tb_b[i];
    end
  end

  // external ripple adder
  always_comb begin
    add_full       = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {16'h0000, bus.add_cin};
    add_low        = {1'b0, bus.add_a[14:0]} + {1'b0, bus.add_b[14:0]} + {15'h0000, bus.add_cin};
    bus.add_s      = add_full[15:0];
    bus.add_cout   = add_full[16];
    bus.add_cout14 = add_low[15];
  end

  function automatic void ref_op(input int a, input int b, input bit sub,
                                 output logic [15:0] s, output bit c, output bit o);
    int sa, sb, r;
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    if (sub) begin
      s = 16'(a - b);
      c = (a >= b);
      r = sa - sb;
    end else begin
      s = 16'(a + b);
      c = (a + b) > 65535;
      r = sa + sb;
    end
    o = (r > 32767) || (r < -32768);
`ifdef ADDER_ARB_SAT_EN
    if (o) s = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
  endfunction

  task automatic new_op(input int i);
    int sel;
    sel = $urandom_range(0, 3);
    tb_a[i]   = (sel == 0) ? 16'h7FFF : 16'($urandom);
    tb_b[i]   = (sel == 1) ? 16'h8000 : 16'($urandom);
    tb_sub[i] = 1'($urandom);
  endtask

  // expectations for the cycle about to be clocked (inputs already settled)
  task automatic eval_phase();
    int i;
    @(negedge clk);
    e_win = -1;
    for (int k = 0; k < N; k++) begin
      i = (m_ptr + k) % N;
      if (e_win < 0 && tb_valid[i]) e_win = i;
    end
    e_take  = rst_n && (e_win >= 0) && (!m_valid || bus.rsp_ready);
    e_ready = '0;
    if (e_take) e_ready[e_win] = 1'b1;
    e_add_a = (e_win >= 0) ? tb_a[e_win] : 16'h0000;
    e_add_b = (e_win >= 0) ? (tb_sub[e_win] ? ~tb_b[e_win] : tb_b[e_win]) : 16'h0000;
    e_cin   = (e_win >= 0) ? tb_sub[e_win] : 1'b0;
  endtask

  task automatic edge_phase();
    @(posedge clk);
    m_xfer = -1;
    if (!rst_n) begin
      m_ptr = 0; m_valid = 1'b0; m_id = 2'd0; m_sum = 16'h0000; m_carry = 1'b0; m_ovf = 1'b0;
    end else if (e_take) begin
      ref_op(int'(tb_a[e_win]), int'(tb_b[e_win]), tb_sub[e_win], m_sum, m_carry, m_ovf);
      m_valid = 1'b1;
      m_id    = 2'(e_win);
      m_ptr   = (e_win + 1) % N;
      m_xfer  = e_win;
    end else if (m_valid && bus.rsp_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tb_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) new_op(i);
    edge_phase();
    for (int c = 0; c < 2; c++) begin
      eval_phase();
      total++;
      if (bus.req_ready !== 4'b0000) begin
        bad++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready);
      end
      total++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_ovf} !== 21'd0) begin
        bad++; $display("FAIL reset_rsp got v=%b id=%0d sum=%h c=%b o=%b exp all 0",
                        bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_ovf);
      end
      edge_phase();
    end
    rst_n = 1'b1;
    eval_phase();
    total++;
    if (bus.req_ready !== 4'b0001) begin
      bad++; $display("FAIL reset_first_grant got=%b exp=0001", bus.req_ready);
    end
    edge_phase();
    new_op(0);
  endtask

  task automatic test_round_robin();
    for (int c = 0; c < 12; c++) begin
      eval_phase();
      total++;
      if (bus.req_ready !== 4'(1 << ((1 + c) % N))) begin
        bad++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", c, bus.req_ready, 4'(1 << ((1 + c) % N)));
      end
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(c % N) || bus.rsp_sum !== m_sum) begin
        bad++; $display("FAIL rr_rsp cyc=%0d got v=%b id=%0d sum=%h exp v=1 id=%0d sum=%h",
                        c, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, c % N, m_sum);
      end
      edge_phase();
      if (m_xfer >= 0) new_op(m_xfer);
    end
  endtask

  task automatic drain();
    tb_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      eval_phase();
      edge_phase();
    end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_sum;
    drain();
`ifdef ADDER_ARB_SAT_EN
    exp_sum = 16'h7FFF;
`else
    exp_sum = 16'h8000;
`endif
    tb_valid = 4'b0010; tb_a[1] = 16'h7FFF; tb_b[1] = 16'h0001; tb_sub[1] = 1'b0;
    eval_phase();
    total++;
    if (bus.req_ready !== 4'b0010) begin
      bad++; $display("FAIL ovf_grant got=%b exp=0010", bus.req_ready);
    end
    edge_phase();
    tb_valid = '0;
    eval_phase();
    total++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_ovf} !== {1'b1, 2'd1, exp_sum, 1'b0, 1'b1}) begin
      bad++; $display("FAIL ovf_rsp got v=%b id=%0d sum=%h c=%b o=%b exp v=1 id=1 sum=%h c=0 o=1",
                      bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_ovf, exp_sum);
    end
    edge_phase();
  endtask

  task automatic test_sub();
    drain();
    tb_valid = 4'b0100; tb_a[2] = 16'h0003; tb_b[2] = 16'h0005; tb_sub[2] = 1'b1;
    eval_phase();
    total++;
    if (bus.add_a !== 16'h0003 || bus.add_b !== 16'hFFFA || bus.add_cin !== 1'b1) begin
      bad++; $display("FAIL sub_drive got a=%h b=%h cin=%b exp a=0003 b=FFFA cin=1",
                      bus.add_a, bus.add_b, bus.add_cin);
    end
    edge_phase();
    tb_valid = '0;
    eval_phase();
    total++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_ovf} !== {1'b1, 2'd2, 16'hFFFE, 1'b0, 1'b0}) begin
      bad++; $display("FAIL sub_rsp got v=%b id=%0d sum=%h c=%b o=%b exp v=1 id=2 sum=FFFE c=0 o=0",
                      bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_ovf);
    end
    total++;
    if (bus.add_a !== 16'h0000 || bus.add_b !== 16'h0000 || bus.add_cin !== 1'b0) begin
      bad++; $display("FAIL idle_drive got a=%h b=%h cin=%b exp zeros", bus.add_a, bus.add_b, bus.add_cin);
    end
    edge_phase();
  endtask

  task automatic test_stall();
    logic [20:0] snap;
    new_op(0); new_op(3);
    tb_valid = 4'b1001;
    bus.rsp_ready = 1'b1;
    eval_phase();
    edge_phase();
    if (m_xfer >= 0) new_op(m_xfer);
    bus.rsp_ready = 1'b0;
    snap = {1'b1, m_id, m_sum, m_carry, m_ovf};
    for (int c = 0; c < 3; c++) begin
      eval_phase();
      total++;
      if (bus.req_ready !== 4'b0000) begin
        bad++; $display("FAIL stall_ready cyc=%0d got=%b exp=0000", c, bus.req_ready);
      end
      total++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_ovf} !== snap) begin
        bad++; $display("FAIL stall_hold cyc=%0d got=%h exp=%h", c,
                        {bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_ovf}, snap);
      end
      edge_phase();
    end
    bus.rsp_ready = 1'b1;
    eval_phase();
    total++;
    if (bus.req_ready !== e_ready) begin
      bad++; $display("FAIL stall_release got=%b exp=%b", bus.req_ready, e_ready);
    end
    edge_phase();
    if (m_xfer >= 0) new_op(m_xfer);
  endtask

  task automatic test_reset_inflight();
    drain();
    tb_valid = 4'b0010; new_op(1);
    eval_phase();
    edge_phase();
    tb_valid = '0;
    bus.rsp_ready = 1'b0;
    eval_phase();
    total++;
    if (bus.rsp_valid !== 1'b1) begin
      bad++; $display("FAIL inflight_valid got=%b exp=1", bus.rsp_valid);
    end
    rst_n = 1'b0;
    edge_phase();
    eval_phase();
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
      bad++; $display("FAIL inflight_drop got v=%b rdy=%b exp v=0 rdy=0000", bus.rsp_valid, bus.req_ready);
    end
    edge_phase();
    rst_n = 1'b1;
    tb_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    eval_phase();
    total++;
    if (bus.req_ready !== 4'b0001) begin
      bad++; $display("FAIL inflight_restart got=%b exp=0001", bus.req_ready);
    end
    edge_phase();
    if (m_xfer >= 0) new_op(m_xfer);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      eval_phase();
      total++;
      if (bus.req_ready !== e_ready) begin
        bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, bus.req_ready, e_ready);
      end
      total++;
      if (bus.add_a !== e_add_a || bus.add_b !== e_add_b || bus.add_cin !== e_cin) begin
        bad++; $display("FAIL rnd_drive cyc=%0d got a=%h b=%h cin=%b exp a=%h b=%h cin=%b",
                        c, bus.add_a, bus.add_b, bus.add_cin, e_add_a, e_add_b, e_cin);
      end
      total++;
      if (bus.rsp_valid !== m_valid ||
          (m_valid && {bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_ovf} !== {m_id, m_sum, m_carry, m_ovf})) begin
        bad++; $display("FAIL rnd_rsp cyc=%0d got v=%b id=%0d sum=%h c=%b o=%b exp v=%b id=%0d sum=%h c=%b o=%b",
                        c, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.rsp_ovf,
                        m_valid, m_id, m_sum, m_carry, m_ovf);
      end
      edge_phase();
      for (int i = 0; i < N; i++) begin
        if (i == m_xfer || !tb_valid[i]) begin
          new_op(i);
          tb_valid[i] = 1'($urandom);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      tb_a[i] = 16'h0000; tb_b[i] = 16'h0000;
    end
    test_reset();
    test_round_robin();
    test_overflow();
    test_sub();
    test_stall();
    test_reset_inflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
